// File: rtl/pool_window_scheduler.sv
// 2x2 pooling window scheduler: fetches windows from the feature SRAM,
// hands them to the pooling unit and writes each pooled result back.
module pool_window_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [DIM_WIDTH-1:0]    fmap_width,
  input  logic [DIM_WIDTH-1:0]    fmap_height,
  input  logic                    stride2,
  input  logic [ADDR_WIDTH-1:0]   in_base,
  input  logic [ADDR_WIDTH-1:0]   out_base,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  output logic [4*DATA_WIDTH-1:0] win_data,
  output logic                    win_valid,
  input  logic                    win_ready,
  input  logic [DATA_WIDTH-1:0]   res_data,
  input  logic                    res_valid,
  output logic                    res_ready,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE, WAIT_RES, WRITE, DONE
  } state_t;

  localparam logic [DIM_WIDTH-1:0] D1 = 1;
  localparam logic [DIM_WIDTH-1:0] D2 = 2;

  state_t                state;
  logic [DIM_WIDTH-1:0]  w, ow, oh, orow, ocol;
  logic [DIM_WIDTH-1:0]  nrow, ncol;
  logic                  s2, last;
  logic [ADDR_WIDTH-1:0] ibase, obase;
  logic [2:0]            fcnt;
  logic [DATA_WIDTH-1:0] slot [4];

  // Element k of the window at output (r,c); k[1] picks row, k[0] column.
  function automatic logic [ADDR_WIDTH-1:0] raddr(
    input logic [DIM_WIDTH-1:0] r,
    input logic [DIM_WIDTH-1:0] c,
    input logic [1:0]           k
  );
    logic [ADDR_WIDTH-1:0] row, col;
    row = (ADDR_WIDTH'(r) << s2) + ADDR_WIDTH'(k[1]);
    col = (ADDR_WIDTH'(c) << s2) + ADDR_WIDTH'(k[0]);
    return ibase + row * ADDR_WIDTH'(w) + col;
  endfunction

  assign last = (ocol == ow - D1) && (orow == oh - D1);
  assign ncol = (ocol == ow - D1) ? '0 : ocol + D1;
  assign nrow = (ocol == ow - D1) ? orow + D1 : orow;

  assign win_data = {slot[3], slot[2], slot[1], slot[0]};
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      win_valid <= 1'b0;
      res_ready <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      w         <= '0;
      ow        <= '0;
      oh        <= '0;
      s2        <= 1'b0;
      ibase     <= '0;
      obase     <= '0;
      orow      <= '0;
      ocol      <= '0;
      fcnt      <= '0;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
    end else if (abort && state != IDLE) begin
      state     <= IDLE;
      rd_en     <= 1'b0;
      win_valid <= 1'b0;
      res_ready <= 1'b0;
      wr_en     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      orow      <= '0;
      ocol      <= '0;
      fcnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start && !abort) begin
            w     <= fmap_width;
            s2    <= stride2;
            ibase <= in_base;
            obase <= out_base;
            orow  <= '0;
            ocol  <= '0;
            fcnt  <= '0;
            ow    <= stride2 ? ((fmap_width - D2) >> 1) + D1
                             : fmap_width - D1;
            oh    <= stride2 ? ((fmap_height - D2) >> 1) + D1
                             : fmap_height - D1;
            if (fmap_width < D2 || fmap_height < D2) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              // Window 0 always starts at the plane base.
              state   <= FETCH;
              rd_en   <= 1'b1;
              rd_addr <= in_base;
            end
          end
        end
        FETCH: begin
          if (fcnt != 3'd0) slot[fcnt[1:0] - 2'd1] <= rd_data;
          if (fcnt < 3'd3) rd_addr <= raddr(orow, ocol, fcnt[1:0] + 2'd1);
          else             rd_en   <= 1'b0;
          if (fcnt == 3'd4) begin
            fcnt      <= '0;
            state     <= ISSUE;
            win_valid <= 1'b1;
          end else begin
            fcnt <= fcnt + 3'd1;
          end
        end
        ISSUE: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            res_ready <= 1'b1;
            state     <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (res_valid) begin
            res_ready <= 1'b0;
            wr_en     <= 1'b1;
            wr_data   <= res_data;
            wr_addr   <= obase + ADDR_WIDTH'(orow) * ADDR_WIDTH'(ow)
                         + ADDR_WIDTH'(ocol);
            state     <= WRITE;
          end
        end
        WRITE: begin
          wr_en <= 1'b0;
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b0;
          end else begin
            orow    <= nrow;
            ocol    <= ncol;
            state   <= FETCH;
            rd_en   <= 1'b1;
            rd_addr <= raddr(nrow, ncol, 2'd0);
          end
        end
        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_window_scheduler.sv
// Scoreboard bench for pool_window_scheduler: directed passes with
// hand-computed read/write addresses checked by a decoupled monitor.
module tb_pool_window_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, stride2;
  logic [7:0]  fmap_width, fmap_height;
  logic [15:0] in_base, out_base;
  logic        rd_en, win_valid, win_ready, res_valid, res_ready;
  logic        wr_en, busy, done, err;
  logic [15:0] rd_addr, rd_data, res_data, wr_addr, wr_data;
  logic [63:0] win_data;

  always #5 clk = ~clk;

  pool_window_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .fmap_width(fmap_width), .fmap_height(fmap_height),
    .stride2(stride2), .in_base(in_base), .out_base(out_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          gap;
  } wr_t;
  typedef struct {
    logic err;
    int   deadline;
  } dn_t;

  localparam int BIG = 1 << 30;

  logic [15:0] exp_rd[$];
  wr_t         exp_wr[$];
  dn_t         exp_dn[$];
  int          exp_iss[$];

  int vectors = 0, miscompares = 0, cyc = 0, last_wr = 0;
  int idle_req = 0, idle_ack = 0, drain_req = 0, drain_ack = 0;
  int stall_n = 0, run_len = 0, exp_len = 0;
  logic [15:0] ra;
  wr_t         wt;
  dn_t         dt;
  logic [63:0] pv_data = '0;
  logic        pv_valid = 1'b0, pv_ready = 1'b0;

  function automatic logic [15:0] mv(input logic [15:0] a);
    return a * 16'd37 + 16'd5;
  endfunction

  function automatic logic [15:0] pool(
    input logic [15:0] e0, input logic [15:0] e1,
    input logic [15:0] e2, input logic [15:0] e3
  );
    return e0 + e1 * 16'd3 + e2 * 16'd5 + e3 * 16'd7;
  endfunction

  task automatic push_win(
    input logic [15:0] a0, input logic [15:0] a1,
    input logic [15:0] a2, input logic [15:0] a3,
    input logic [15:0] wa, input int gap
  );
    wr_t e;
    exp_rd.push_back(a0);
    exp_rd.push_back(a1);
    exp_rd.push_back(a2);
    exp_rd.push_back(a3);
    e.addr = wa;
    e.data = pool(mv(a0), mv(a1), mv(a2), mv(a3));
    e.gap  = gap;
    exp_wr.push_back(e);
    exp_iss.push_back(stall_n + 1);
  endtask

  task automatic push_done(input logic e, input int deadline);
    dn_t d;
    d.err      = e;
    d.deadline = deadline;
    exp_dn.push_back(d);
  endtask

  // Feature SRAM: one-cycle read latency.
  logic        pend = 1'b0;
  logic [15:0] pa = '0;
  initial begin
    rd_data = '0;
    forever begin
      @(negedge clk);
      rd_data = pend ? mv(pa) : 16'h0;
      pend    = rd_en;
      pa      = rd_addr;
    end
  end

  // Pooling unit: stalls stall_n cycles, then returns one result.
  logic [63:0] hold;
  initial begin
    win_ready = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    forever begin
      @(negedge clk);
      res_valid = 1'b0;
      if (win_valid && !win_ready) begin
        hold = win_data;
        for (int i = 0; i < stall_n; i++) @(negedge clk);
        win_ready = 1'b1;
        @(negedge clk);
        win_ready = 1'b0;
        res_data  = pool(hold[15:0], hold[31:16], hold[47:32], hold[63:48]);
        res_valid = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rd_en) begin
      vectors++;
      if (exp_rd.size() == 0) begin
        miscompares++;
        $display("FAIL rd_addr: unexpected read at %h", rd_addr);
      end else begin
        ra = exp_rd.pop_front();
        if (rd_addr !== ra) begin
          miscompares++;
          $display("FAIL rd_addr: got %h want %h", rd_addr, ra);
        end
      end
    end
    if (wr_en) begin
      vectors++;
      if (exp_wr.size() == 0) begin
        miscompares++;
        $display("FAIL wr: unexpected write %h at %h", wr_data, wr_addr);
      end else begin
        wt = exp_wr.pop_front();
        if (wr_addr !== wt.addr || wr_data !== wt.data) begin
          miscompares++;
          $display("FAIL wr: got %h@%h want %h@%h",
                   wr_data, wr_addr, wt.data, wt.addr);
        end
        if (wt.gap > 0) begin
          vectors++;
          if (cyc - last_wr != wt.gap) begin
            miscompares++;
            $display("FAIL wr_gap: got %0d want %0d", cyc - last_wr, wt.gap);
          end
        end
      end
      last_wr = cyc;
    end
    if (done) begin
      vectors++;
      if (exp_dn.size() == 0) begin
        miscompares++;
        $display("FAIL done: unexpected pulse err=%b", err);
      end else begin
        dt = exp_dn.pop_front();
        if (err !== dt.err || cyc > dt.deadline) begin
          miscompares++;
          $display("FAIL done: err=%b cyc=%0d want err=%b by %0d",
                   err, cyc, dt.err, dt.deadline);
        end
      end
    end
    if (win_valid && pv_valid && !pv_ready) begin
      vectors++;
      if (win_data !== pv_data) begin
        miscompares++;
        $display("FAIL win_hold: got %h want %h", win_data, pv_data);
      end
    end
    if (win_valid) begin
      run_len++;
    end else if (run_len > 0) begin
      vectors++;
      exp_len = (exp_iss.size() == 0) ? 0 : exp_iss.pop_front();
      if (run_len != exp_len) begin
        miscompares++;
        $display("FAIL issue_len: got %0d want %0d", run_len, exp_len);
      end
      run_len = 0;
    end
    pv_valid = win_valid;
    pv_ready = win_ready;
    pv_data  = win_data;
    if (idle_req != idle_ack) begin
      idle_ack++;
      vectors++;
      if ({busy, rd_en, wr_en, win_valid, res_ready, done} !== 6'b0) begin
        miscompares++;
        $display("FAIL idle: got %b want 000000",
                 {busy, rd_en, wr_en, win_valid, res_ready, done});
      end
    end
    if (drain_req != drain_ack) begin
      drain_ack++;
      vectors++;
      if (exp_rd.size() + exp_wr.size() + exp_dn.size() + exp_iss.size() != 0) begin
        miscompares++;
        $display("FAIL drain: left rd=%0d wr=%0d done=%0d iss=%0d want 0",
                 exp_rd.size(), exp_wr.size(), exp_dn.size(), exp_iss.size());
      end
    end
  end

  task automatic launch(
    input logic [7:0] w, input logic [7:0] h, input logic s,
    input logic [15:0] ib, input logic [15:0] ob
  );
    fmap_width  = w;
    fmap_height = h;
    stride2     = s;
    in_base     = ib;
    out_base    = ob;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      $display("FAIL %s: timeout busy=%b want 0", name, busy);
      $fatal(1);
    end
    repeat (2) @(negedge clk);
    drain_req++;
    @(negedge clk);
  endtask

  task automatic pass_4x4(input logic [15:0] ob);
    push_win(16'd0,  16'd1,  16'd4,  16'd5,  ob,         0);
    push_win(16'd2,  16'd3,  16'd6,  16'd7,  ob + 16'd1, 8);
    push_win(16'd8,  16'd9,  16'd12, 16'd13, ob + 16'd2, 8);
    push_win(16'd10, 16'd11, 16'd14, 16'd15, ob + 16'd3, 8);
    push_done(1'b0, BIG);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    fmap_width = '0; fmap_height = '0; stride2 = 1'b0;
    in_base = '0; out_base = '0;
    repeat (3) @(negedge clk);
    idle_req++;
    rst_n = 1'b1;
    @(negedge clk);

    stall_n = 0;
    pass_4x4(16'h100);
    launch(8'd4, 8'd4, 1'b1, 16'h0, 16'h100);
    wait_idle("pass_4x4");

    stall_n = 3;
    push_win(16'h20, 16'h21, 16'h23, 16'h24, 16'h200, 0);
    push_win(16'h21, 16'h22, 16'h24, 16'h25, 16'h201, 0);
    push_win(16'h23, 16'h24, 16'h26, 16'h27, 16'h202, 0);
    push_win(16'h24, 16'h25, 16'h27, 16'h28, 16'h203, 0);
    push_done(1'b0, BIG);
    launch(8'd3, 8'd3, 1'b0, 16'h20, 16'h200);
    wait_idle("pass_3x3");
    stall_n = 0;

    push_done(1'b1, cyc + 3);
    launch(8'd1, 8'd4, 1'b0, 16'h0, 16'h0);
    wait_idle("w1_err");
    push_done(1'b1, cyc + 3);
    launch(8'd4, 8'd1, 1'b1, 16'h0, 16'h0);
    wait_idle("h1_err");

    push_win(16'd0, 16'd1, 16'd4, 16'd5, 16'h100, 0);
    exp_rd.push_back(16'd2);
    launch(8'd4, 8'd4, 1'b1, 16'h0, 16'h100);
    for (int i = 0; i < 100 && !wr_en; i++) @(negedge clk);
    for (int i = 0; i < 20 && !rd_en; i++) @(negedge clk);
    if (!rd_en) begin
      $display("FAIL abort_setup: rd_en=%b want 1", rd_en);
      $fatal(1);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    idle_req++;
    repeat (6) @(negedge clk);
    drain_req++;
    @(negedge clk);
    pass_4x4(16'h100);
    launch(8'd4, 8'd4, 1'b1, 16'h0, 16'h100);
    wait_idle("restart");

    abort = 1'b1;
    launch(8'd4, 8'd4, 1'b1, 16'h0, 16'h100);
    abort = 1'b0;
    idle_req++;
    repeat (4) @(negedge clk);
    drain_req++;
    @(negedge clk);

    pass_4x4(16'h300);
    launch(8'd4, 8'd4, 1'b1, 16'h0, 16'h300);
    repeat (10) @(negedge clk);
    launch(8'd3, 8'd3, 1'b0, 16'h50, 16'h0);
    wait_idle("start_busy");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
